serial_subtractor: RTL and testbench

- Bit-serial unsigned/two's-complement subtractor: computes diff = a - b, LSB first, one bit per clock.
- Inverse operation to the combinational four-bit ripple adder. Trades area for latency: a single full-subtractor cell is reused WIDTH times.
- Start/done handshake; sits beside the adder datapath for ALU-style use, and its result can be cross-checked against the adder (diff + b == a).

---
 rtl/serial_subtractor.sv | 155 +++++++++++++++
 tb/tb_serial_subtractor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one full-subtractor step per clock.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             borrow_q, borrow_d;

  logic a0, b0, d_bit, br_nxt;
  logic load, last_shift;

  assign a0     = a_sh_q[0];
  assign b0     = b_sh_q[0];
  assign d_bit  = a0 ^ b0 ^ br_q;
  assign br_nxt = (~a0 & b0) | (~(a0 ^ b0) & br_q);

  // A new operation is accepted from IDLE or directly out of DONE (no bubble).
  assign load       = start && ((state_q == StIdle) || (state_q == StDone));
  assign last_shift = (state_q == StShift) && (cnt_q == LastCnt);

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    borrow_d = borrow_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (load) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {d_bit, res_q[WIDTH-1:1]};
        br_d   = br_nxt;
        cnt_d  = cnt_q + CntW'(1);
        if (last_shift) begin
          diff_d   = {d_bit, res_q[WIDTH-1:1]};
          borrow_d = br_nxt;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted out during SHIFT, so keep a copy for the overflow test.
  logic a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;

  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if (load) begin
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end
    if (last_shift) begin
      ovf_d = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done is high.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
    int unsigned  cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = q.pop_front();
        chk("diff", 32'(diff), 32'(e.d));
        chk("borrow", 32'(borrow), 32'(e.br));
        chk("done_cycle", cyc, e.cyc);
        chk("busy_at_done", 32'(busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(ovf), 32'(e.ov));
`endif
      end
    end
  end

  // Drive operands with start for one cycle; returns at the negedge after acceptance.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ed, input logic eb, input logic eo,
                       input bit push);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (push) q.push_back('{d: ed, br: eb, ov: eo, cyc: cyc + W});
    chk("busy_after_accept", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (q.size() == 0) break;
    end
    chk("queue_drained", q.size(), 32'd0);
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 10 - 2: busy for exactly W cycles
    issue(4'd10, 4'd2, 4'd8, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("busy_during_shift", 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk("busy_low_at_done", 32'(busy), 32'd0);
    wait_idle();

    // 2 - 10: borrow, result held while idle
    issue(4'd2, 4'd10, 4'd8, 1'b1, 1'b1, 1'b1);
    wait_idle();
    repeat (20) begin
      @(negedge clk);
      chk("diff_hold", 32'(diff), 32'd8);
    end
    chk("borrow_hold", 32'(borrow), 32'd1);

    // Back-to-back: 15-15 then 0-0 with start held through DONE
    @(negedge clk);
    a = 4'd15;
    b = 4'd15;
    start = 1'b1;
    @(posedge clk);
    #1;
    q.push_back('{d: 4'd0, br: 1'b0, ov: 1'b0, cyc: cyc + W});
    a = 4'd0;
    b = 4'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) break;
    end
    @(posedge clk);
    #1;
    q.push_back('{d: 4'd0, br: 1'b0, ov: 1'b0, cyc: cyc + W});
    chk("b2b_busy", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Start during SHIFT is ignored
    issue(4'd9, 4'd3, 4'd6, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    a = 4'd1;
    b = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("ignored_start_diff", 32'(diff), 32'd6);

    // Reset mid-SHIFT abandons the operation
    issue(4'd12, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    chk("midrst_borrow", 32'(borrow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_done_after_abort", done_cnt, 32'd5);
    issue(4'd12, 4'd5, 4'd7, 1'b0, 1'b1, 1'b1);
    wait_idle();

    // Signed overflow vectors
    issue(4'd7, 4'd8, 4'd15, 1'b1, 1'b1, 1'b1);
    wait_idle();
    issue(4'd3, 4'd1, 4'd2, 1'b0, 1'b0, 1'b1);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("done_count", done_cnt, 32'd8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
